// File: rtl/tdm_pkg.sv
// Shared constants for the 16-lane TDM link, used on both the mux and demux sides.
// lane_lo gives the low bit of lane k inside a packed frame vector.
package tdm_pkg;

   localparam int WIDTH = 16;
   localparam int LANES = 16;
   localparam int SEL_W = 4;

   function automatic int lane_lo(input int k);
      return k * WIDTH;
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM receiver: counts modulo LANES, with clear and a load-to-1 used on resync.
// Priority is clear, then load-to-1, then increment.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_load1,
   input  logic             i_clr,
   output logic [SEL_W-1:0] o_slot,
   output logic             o_last
);

   logic [SEL_W-1:0] r_slot;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot <= '0;
      end else if (i_clr) begin
         r_slot <= '0;
      end else if (i_load1) begin
         r_slot <= SEL_W'(1);
      end else if (i_inc) begin
         r_slot <= r_slot + 1'b1;
      end
   end

   assign o_slot = r_slot;
   assign o_last = (r_slot == SEL_W'(LANES - 1));

endmodule

// File: rtl/tdm_demux16.sv
// 1:16 TDM word demultiplexer: collects slot words 0..LANES-2, closes the frame on the
// last slot and offers all lanes in parallel on a valid/ready output.
module tdm_demux16
   import tdm_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   input  logic                   in_sof,
   output logic                   in_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SEL_W-1:0]       slot,
   output logic                   frame_err
);

   // Handshake: a word moves when in_valid & in_ready; a frame moves when out_valid & out_ready.
   // Only the last slot is back-pressured, and only while an unconsumed frame is still held.
   logic [WIDTH-1:0]       r_collect [0:LANES-2];
   logic [LANES*WIDTH-1:0] r_out_data;
   logic                   r_out_valid;
   logic                   r_frame_err;
   logic [SEL_W-1:0]       w_slot;
   logic                   w_last;
   logic                   w_stall;
   logic                   w_acc;
   logic                   w_resync;
   logic                   w_close;
   logic [SEL_W-1:0]       w_wr_idx;

   assign w_stall  = w_last & r_out_valid & ~out_ready;
   assign in_ready = ~w_stall;
   assign w_acc    = in_valid & in_ready;
   // A start-of-frame away from slot 0 wins over a frame close, even on the last slot.
   assign w_resync = w_acc & in_sof & (w_slot != '0);
   assign w_close  = w_acc & w_last & ~w_resync;
   assign w_wr_idx = w_resync ? '0 : w_slot;

   tdm_slot_ctr u_slot_ctr (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_acc & ~w_resync),
      .i_load1 (w_resync),
      .i_clr   (w_close),
      .o_slot  (w_slot),
      .o_last  (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LANES - 1; k++) begin
            r_collect[k] <= '0;
         end
      end else if (w_acc & ~w_close) begin
         r_collect[w_wr_idx] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_resync;
         if (w_close) begin
            for (int k = 0; k < LANES - 1; k++) begin
               r_out_data[lane_lo(k) +: WIDTH] <= r_collect[k];
            end
            r_out_data[lane_lo(LANES - 1) +: WIDTH] <= in_data;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign slot      = w_slot;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_tdm_demux16.sv
// Randomized bench for tdm_demux16: a word-level reference model feeds an expected-frame queue
// that a negedge monitor checks against the DUT output handshake.
module tb_tdm_demux16;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  in_data;
   logic         in_valid;
   logic         in_sof;
   logic         in_ready;
   logic [255:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   slot;
   logic         frame_err;

   int n_chk  = 0;
   int n_pass = 0;

   logic [255:0] exp_q[$];
   logic [15:0]  m_cur[$];
   int           m_pend = 0;
   logic         m_err  = 1'b0;
   logic         mon_en = 1'b0;

   tdm_demux16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .slot      (slot),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: a frame is the run of accepted words since the last frame boundary
   // or start-of-frame; 16 words make a frame, a start-of-frame mid-run restarts it.
   always @(posedge clk) begin
      if (rst) begin
         m_cur.delete();
         exp_q.delete();
         m_pend = 0;
         m_err  = 1'b0;
         mon_en = 1'b1;
      end else begin
         logic         stall;
         logic         consume;
         logic         made;
         logic [255:0] f;
         stall   = (m_cur.size() == 15) && (m_pend > 0) && !out_ready;
         consume = (m_pend > 0) && out_ready;
         made    = 1'b0;
         m_err   = 1'b0;
         if (in_valid && !stall) begin
            if (in_sof && m_cur.size() != 0) begin
               m_err = 1'b1;
               m_cur.delete();
               m_cur.push_back(in_data);
            end else begin
               m_cur.push_back(in_data);
               if (m_cur.size() == 16) begin
                  for (int k = 0; k < 16; k++) f[k*16 +: 16] = m_cur[k];
                  exp_q.push_back(f);
                  m_cur.delete();
                  made = 1'b1;
               end
            end
         end
         m_pend = m_pend - (consume ? 1 : 0) + (made ? 1 : 0);
      end
   end

   // Monitor: per-cycle status against the model, frame content against the queue head.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("slot", 256'(slot), 256'(m_cur.size()));
         chk("out_valid", 256'(out_valid), 256'(m_pend > 0));
         chk("frame_err", 256'(frame_err), 256'(m_err));
         chk("in_ready", 256'(in_ready),
             256'(!((m_cur.size() == 15) && (m_pend > 0) && !out_ready)));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("frame_unexpected", 256'(out_valid), 256'(0));
            end else begin
               chk("out_data", out_data, exp_q[0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Holds the word until accepted; after a few stalled cycles it releases out_ready itself.
   task automatic send(input logic [15:0] d, input logic sof);
      int   n;
      logic took;
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      n        = 0;
      do begin
         @(posedge clk);
         took = in_ready;
         #1;
         n++;
         if (!took && n >= 4) out_ready = 1'b1;
      end while (!took && n < 200);
      chk("accept", 256'(took), 256'(1));
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] base, input int gap);
      for (int k = 0; k < 16; k++) begin
         send(base + 16'(k), k == 0);
         if (gap > 0) idle(gap);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_data", out_data, 256'(0));
      @(posedge clk);
      #1;

      send_frame(16'h1000, 0);
      idle(2);

      send_frame(16'h2000, 0);
      send_frame(16'h3000, 0);
      idle(2);

      // Back-pressure: pending frame blocks the next frame's last slot.
      out_ready = 1'b0;
      send_frame(16'h4000, 0);
      send_frame(16'h5000, 0);
      out_ready = 1'b1;
      idle(2);

      // Resync on the sixth word, then 15 more words complete the frame.
      for (int k = 0; k < 5; k++) send(16'h6000 + 16'(k), k == 0);
      send(16'h6A00, 1'b1);
      for (int k = 1; k < 16; k++) send(16'h6A00 + 16'(k), 1'b0);
      idle(2);

      // Reset mid-frame with an unconsumed frame held.
      out_ready = 1'b0;
      send_frame(16'h7000, 0);
      for (int k = 0; k < 9; k++) send(16'h7100 + 16'(k), k == 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_data", out_data, 256'(0));
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      send_frame(16'h1000, 1);
      idle(2);

      for (int i = 0; i < 320; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         send(16'($urandom), $urandom_range(0, 15) == 0);
         idle($urandom_range(0, 2));
      end

      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) send(16'($urandom), k == 0);
      idle(4);
      chk("exp_q_drained", 256'(exp_q.size()), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive-side counterpart of the 16:1 word multiplexer. It takes a time-division stream of 16-bit words, one word per slot, with slots 0..15 in order.
- Steers each accepted word into the lane register matching the current slot.
- After slot 15, presents all 16 lanes in parallel as one frame through a valid/ready output.
- Sits at the far end of a serialized 16-lane link and recovers the parallel lane vector that fed the mux selector sweep.

Parameters:
- WIDTH, 16, bits per lane word
- LANES, 16, lanes per frame (power of two)
- SEL_W, 4, slot counter width = log2(LANES)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  serial word for the current slot
- in_valid  in  1  in_data is valid this cycle
- in_sof  in  1  start-of-frame marker, qualified by in_valid; marks a word belonging to slot 0
- in_ready  out  1  block can accept a word this cycle
- out_data  out  LANES*WIDTH  recovered frame; lane k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  out_data holds a complete frame
- out_ready  in  1  downstream accepts the frame
- slot  out  SEL_W  slot index the next accepted word will fill
- frame_err  out  1  one-cycle pulse when in_sof arrives with slot != 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Only rising edges of clk with rst=1 reset state.
- Reset values: slot=0, out_valid=0, out_data=0, frame_err=0, internal collect buffer (lanes 0..LANES-2)=0. Reset mid-frame discards the partial frame and any unconsumed output frame.
- Accept condition: acc = in_valid & in_ready.
- Stall condition: stall = (slot==LANES-1) & out_valid & ~out_ready.
  - in_ready = ~stall.
  - Only the last slot is ever back-pressured; slots 0..LANES-2 always accept.
- Normal accept, slot s < LANES-1 and no resync: collect[s] <= in_data; slot <= s+1.
- Frame close, acc with slot == LANES-1:
  - out_data <= {in_data, collect[LANES-2:0]}, with lane 15 = in_data.
  - out_valid <= 1; slot <= 0.
  - Latency: frame visible the cycle after the slot-15 word is accepted.
- Output handshake:
  - out_valid & out_ready with no frame close in the same cycle: out_valid <= 0.
  - Frame close in the same cycle as out_ready: new frame loads and out_valid stays 1, so full throughput is one frame per LANES cycles with no bubble.
- out_data holds its value while out_valid=1 and out_ready=0. It is stable until consumed.
- Resync, acc & in_sof & slot != 0:
  - frame_err <= 1 for one cycle.
  - The partial frame is dropped; no out_valid is generated for it.
  - collect[0] <= in_data; slot <= 1.
- in_sof with slot == 0: normal accept, no error.
- in_sof is ignored when acc=0.
- Wrap-around: slot counts modulo LANES; no other increment path exists.
- Idle: in_valid=0 holds slot and collect unchanged. Gaps between words are allowed at any slot.

Decomposition:
- Shared package tdm_pkg holds:
  - WIDTH, LANES and SEL_W constants, shared with the mux side.
  - Function lane_lo(k) = k*WIDTH.
- One sub-module, tdm_slot_ctr: SEL_W-bit counter with inc, load-to-1 (resync) and clear, plus a last-slot flag.
- Lane registers, handshake and error logic stay in tdm_demux16.

Test Plan:
- Reset then 16 accepted words 16'h1000+k with in_sof on k=0, out_ready=1 -> one cycle after word 15, out_valid=1 and lane k = 16'h1000+k; frame_err stays 0; slot returns to 0.
- Two back-to-back frames with out_ready=1 -> out_valid pulses once per frame with no stall; in_ready is 1 throughout; the second frame's lane 15 equals its own word 15.
- out_ready=0 while a frame is pending and the next frame reaches slot 15 -> in_ready=0 only at slot 15 and out_data stays unchanged. Raise out_ready -> in_ready=1 the same cycle; the new frame appears the next cycle.
- in_sof on the 6th word (slot=5) -> frame_err high for exactly one cycle, slot=1, no out_valid for the aborted frame. The next 15 words complete a frame with lane 0 = the sof word.
- rst asserted at slot=9 with out_valid=1 -> next cycle slot=0, out_valid=0, out_data=0, frame_err=0.
- in_valid toggling every other cycle through a frame -> the same out_data as the contiguous case; slot advances only on accepted words.
